// File: rtl/univ_reg_pkg.sv
// univ_reg_pkg: shared MODE encoding and field width for the multi-mode register.
// Contents: MODE_W (width of the MODE field) and mode_e (operation select codes).
// Imported by univ_reg and univ_reg_next.
package univ_reg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

endpackage

// File: rtl/univ_reg_next.sv
// univ_reg_next: purely combinational next-state logic for univ_reg.
// Ports: i_q/i_cout current state, i_d load data, i_sin serial in, i_mode op select;
//        o_q/o_cout the state the register takes on an enabled active edge.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  i_q,
  input  logic              i_cout,
  input  logic [WIDTH-1:0]  i_d,
  input  logic              i_sin,
  input  logic [MODE_W-1:0] i_mode,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_cout
);

  // One extra bit on the arithmetic so the carry/borrow falls out as the MSB.
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  assign w_inc = {1'b0, i_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, i_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    o_q    = i_q;
    o_cout = i_cout;
    case (mode_e'(i_mode))
      MODE_HOLD: begin
        o_q    = i_q;
        o_cout = i_cout;
      end
      MODE_LOAD: begin
        o_q    = i_d;
        o_cout = 1'b0;
      end
      MODE_SHL: begin
        o_q    = {i_q[WIDTH-2:0], i_sin};
        o_cout = i_q[WIDTH-1];
      end
      MODE_SHR: begin
        o_q    = {i_sin, i_q[WIDTH-1:1]};
        o_cout = i_q[0];
      end
      MODE_ROL: begin
        o_q    = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_cout = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_q    = {i_q[0], i_q[WIDTH-1:1]};
        o_cout = i_q[0];
      end
      MODE_INC: begin
        o_q    = w_inc[WIDTH-1:0];
        o_cout = w_inc[WIDTH];
      end
      MODE_DEC: begin
        o_q    = w_dec[WIDTH-1:0];
        o_cout = w_dec[WIDTH];
      end
      default: begin
        o_q    = i_q;
        o_cout = i_cout;
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit multi-mode register (load/shift/rotate/inc/dec), edge selectable by NEGEDGE.
// Ports: CLK clock, R async active-high reset, EN update enable, MODE op select, D load data,
//        SIN serial in; Q contents, Q_ = ~Q, COUT registered carry/shift-out, ZERO = (Q == 0).
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               NEGEDGE   = 1'b1
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]  D,
  input  logic              SIN,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Q_,
  output logic              COUT,
  output logic              ZERO
);

  logic [WIDTH-1:0] r_q;
  logic             r_cout;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_cout_nxt;

  univ_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_q    (r_q),
    .i_cout (r_cout),
    .i_d    (D),
    .i_sin  (SIN),
    .i_mode (MODE),
    .o_q    (w_q_nxt),
    .o_cout (w_cout_nxt)
  );

  // Capture edge is fixed at elaboration; reset is edge-independent and wins over everything.
  if (NEGEDGE) begin : g_neg
    always_ff @(negedge CLK or posedge R) begin
      if (R) begin
        r_q    <= RESET_VAL;
        r_cout <= 1'b0;
      end else if (EN) begin
        r_q    <= w_q_nxt;
        r_cout <= w_cout_nxt;
      end
    end
  end else begin : g_pos
    always_ff @(posedge CLK or posedge R) begin
      if (R) begin
        r_q    <= RESET_VAL;
        r_cout <= 1'b0;
      end else if (EN) begin
        r_q    <= w_q_nxt;
        r_cout <= w_cout_nxt;
      end
    end
  end

  assign Q    = r_q;
  assign Q_   = ~r_q;
  assign COUT = r_cout;
  assign ZERO = (r_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: checks an 8-bit falling-edge instance (RESET_VAL A5) and a 16-bit rising-edge
// instance (RESET_VAL 0) with directed cases and randomized sequences against an arithmetic
// reference model of the operation table.
module tb_univ_reg;

  // 8-bit, falling-edge, RESET_VAL = A5
  logic       clk8, r8, en8, sin8, cout8, zero8;
  logic [2:0] mode8;
  logic [7:0] d8, q8, qn8;

  // 16-bit, rising-edge, RESET_VAL = 0
  logic        clk16, r16, en16, sin16, cout16, zero16;
  logic [2:0]  mode16;
  logic [15:0] d16, q16, qn16;

  int n_tests = 0;
  int n_fail  = 0;

  univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .NEGEDGE(1'b1)) u_dut8 (
    .CLK(clk8), .R(r8), .EN(en8), .MODE(mode8), .D(d8), .SIN(sin8),
    .Q(q8), .Q_(qn8), .COUT(cout8), .ZERO(zero8)
  );

  univ_reg #(.WIDTH(16), .RESET_VAL(16'h0000), .NEGEDGE(1'b0)) u_dut16 (
    .CLK(clk16), .R(r16), .EN(en16), .MODE(mode16), .D(d16), .SIN(sin16),
    .Q(q16), .Q_(qn16), .COUT(cout16), .ZERO(zero16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the operation table written as plain integer arithmetic on a w-bit value.
  function automatic void ref_step(input int w, input int mode, input int q, input int c,
                                   input int d, input int sin, output int qn, output int cn);
    int m, h;
    m = 1 << w;
    h = m / 2;
    case (mode)
      1: begin qn = d;                        cn = 0;           end
      2: begin qn = (q * 2 + sin) % m;        cn = q / h;       end
      3: begin qn = sin * h + q / 2;          cn = q % 2;       end
      4: begin qn = (q * 2) % m + q / h;      cn = q / h;       end
      5: begin qn = (q % 2) * h + q / 2;      cn = q % 2;       end
      6: begin qn = (q + 1) % m;              cn = (q == m - 1) ? 1 : 0; end
      7: begin qn = (q + m - 1) % m;          cn = (q == 0) ? 1 : 0;     end
      default: begin qn = q;                  cn = c;           end
    endcase
  endfunction

  task automatic state8(input string tag, input int eq, input int ec);
    chk({tag, ".q"},    32'(q8),    32'(eq));
    chk({tag, ".qn"},   32'(qn8),   32'(255 - eq));
    chk({tag, ".cout"}, 32'(cout8), 32'(ec));
    chk({tag, ".zero"}, 32'(zero8), (eq == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic state16(input string tag, input int eq, input int ec);
    chk({tag, ".q"},    32'(q16),    32'(eq));
    chk({tag, ".qn"},   32'(qn16),   32'(65535 - eq));
    chk({tag, ".cout"}, 32'(cout16), 32'(ec));
    chk({tag, ".zero"}, 32'(zero16), (eq == 0) ? 32'd1 : 32'd0);
  endtask

  // Full clock period for the 8-bit instance; samples 1 time unit after the falling edge.
  task automatic cyc8();
    #5 clk8 = 1'b1;
    #5 clk8 = 1'b0;
    #1;
  endtask

  task automatic op8(input logic e, input logic [2:0] m, input logic [7:0] d, input logic s);
    en8 = e; mode8 = m; d8 = d; sin8 = s;
    cyc8();
  endtask

  task automatic rise16();
    #4 clk16 = 1'b1;
    #1;
  endtask

  task automatic fall16();
    #4 clk16 = 1'b0;
    #1;
  endtask

  initial begin
    int mq, mc, nq, nc, m, dv, sv, ev;

    clk8 = 1'b0; r8 = 1'b0; en8 = 1'b0; mode8 = 3'd0; d8 = 8'h00; sin8 = 1'b0;
    clk16 = 1'b0; r16 = 1'b0; en16 = 1'b0; mode16 = 3'd0; d16 = 16'h0000; sin16 = 1'b0;

    // ---------------- 8-bit, falling edge ----------------
    #3 r8 = 1'b1;
    #1 state8("rst_async", 8'hA5, 0);
    en8 = 1'b1; mode8 = 3'd1; d8 = 8'h00;
    cyc8(); cyc8();
    state8("rst_ignores_clk", 8'hA5, 0);
    r8 = 1'b0;

    // LOAD 3C: nothing on the rising edge, update on the falling edge
    en8 = 1'b1; mode8 = 3'd1; d8 = 8'h3C;
    #5 clk8 = 1'b1;
    #1 chk("load_rise_q", 32'(q8), 32'hA5);
    #4 clk8 = 1'b0;
    #1 state8("load_3c", 8'h3C, 0);
    op8(1'b0, 3'd1, 8'hFF, 1'b0);
    state8("en0_hold", 8'h3C, 0);

    op8(1'b1, 3'd1, 8'h81, 1'b0);
    op8(1'b1, 3'd2, 8'h00, 1'b0);
    state8("shl", 8'h02, 1);
    op8(1'b1, 3'd0, 8'h55, 1'b1);
    state8("hold_cout", 8'h02, 1);
    op8(1'b1, 3'd3, 8'h00, 1'b1);
    state8("shr", 8'h81, 0);
    op8(1'b1, 3'd5, 8'h00, 1'b0);
    state8("ror", 8'hC0, 1);

    op8(1'b1, 3'd1, 8'hFF, 1'b0);
    op8(1'b1, 3'd6, 8'h00, 1'b0);
    state8("inc_wrap", 8'h00, 1);
    op8(1'b1, 3'd7, 8'h00, 1'b0);
    state8("dec_wrap", 8'hFF, 1);
    op8(1'b1, 3'd7, 8'h00, 1'b0);
    state8("dec", 8'hFE, 0);

    // Counting, then reset asserted mid-period
    op8(1'b1, 3'd1, 8'h10, 1'b0);
    op8(1'b1, 3'd6, 8'h00, 1'b0);
    op8(1'b1, 3'd6, 8'h00, 1'b0);
    op8(1'b1, 3'd6, 8'h00, 1'b0);
    state8("inc3", 8'h13, 0);
    #5 clk8 = 1'b1;
    #2 r8 = 1'b1;
    #1 state8("rst_mid", 8'hA5, 0);
    #2 clk8 = 1'b0;
    #1 chk("rst_mid_fall_q", 32'(q8), 32'hA5);
    r8 = 1'b0;
    op8(1'b1, 3'd6, 8'h00, 1'b0);
    state8("post_rst_inc", 8'hA6, 0);

    // Randomized sequence against the model
    mq = 8'hA6; mc = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        #2 r8 = 1'b1;
        #1;
        mq = 8'hA5; mc = 0;
        state8("rnd8_rst", mq, mc);
        mode8 = 3'($urandom_range(0, 7)); en8 = 1'b1;
        cyc8();
        chk("rnd8_rst_hold_q", 32'(q8), 32'(mq));
        r8 = 1'b0;
      end else begin
        m  = $urandom_range(0, 7);
        dv = $urandom_range(0, 255);
        sv = $urandom_range(0, 1);
        ev = ($urandom_range(0, 3) != 0) ? 1 : 0;
        // Inputs that change and settle between edges must leave no trace
        d8 = 8'($urandom_range(0, 255)); mode8 = 3'($urandom_range(0, 7));
        #1;
        op8(ev[0], m[2:0], dv[7:0], sv[0]);
        if (ev != 0) begin
          ref_step(8, m, mq, mc, dv, sv, nq, nc);
          mq = nq; mc = nc;
        end
        state8("rnd8", mq, mc);
      end
    end

    // ---------------- 16-bit, rising edge ----------------
    #2 r16 = 1'b1;
    #1 state16("rst16", 0, 0);
    r16 = 1'b0;
    en16 = 1'b1; mode16 = 3'd1; d16 = 16'h8000;
    rise16();
    state16("load16", 16'h8000, 0);
    mode16 = 3'd4; d16 = 16'h1234;
    fall16();
    chk("fall16_nochange_q", 32'(q16), 32'h8000);
    rise16();
    state16("rol16", 16'h0001, 1);

    mq = 1; mc = 1;
    for (int i = 0; i < 200; i++) begin
      fall16();
      m  = $urandom_range(0, 7);
      dv = $urandom_range(0, 65535);
      sv = $urandom_range(0, 1);
      ev = ($urandom_range(0, 3) != 0) ? 1 : 0;
      en16 = ev[0]; mode16 = m[2:0]; d16 = dv[15:0]; sin16 = sv[0];
      rise16();
      if (ev != 0) begin
        ref_step(16, m, mq, mc, dv, sv, nq, nc);
        mq = nq; mc = nc;
      end
      state16("rnd16", mq, mc);
      // Disturb inputs during the high phase; the falling edge must not capture them
      en16 = 1'b1; mode16 = 3'($urandom_range(1, 7)); d16 = 16'($urandom_range(0, 65535));
      #2;
      if (i % 4 == 0) begin
        fall16();
        chk("rnd16_fall_q", 32'(q16), 32'(mq));
        rise16();
        if (mode16 != 3'd0) begin
          ref_step(16, int'(mode16), mq, mc, int'(d16), int'(sin16), nq, nc);
          mq = nq; mc = nc;
        end
        state16("rnd16_extra", mq, mc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised edge-triggered multi-mode register for the RISC datapath.
- Next generation of the single-bit resettable D flip-flop, generalised to WIDTH bits, with selectable capture edge.
- Adds load, shift, rotate, increment and decrement modes, a registered carry/shift-out flag and a zero flag.
- Used for the PC, shift unit holding registers and loop counters.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- RESET_VAL, 0, value Q takes while R is high (WIDTH bits).
- NEGEDGE, 1, 1 = capture on falling CLK edge; 0 = capture on rising CLK edge.

Ports:
- CLK  input  1  clock; one clock domain only.
- R  input  1  asynchronous, active-high reset.
- EN  input  1  update enable; 0 = hold regardless of MODE.
- MODE  input  3  operation select (see Behaviour).
- D  input  WIDTH  parallel load data.
- SIN  input  1  serial input bit for shift modes.
- Q  output  WIDTH  register contents.
- Q_  output  WIDTH  bitwise complement of Q, always.
- COUT  output  1  registered carry, borrow or shifted-out bit.
- ZERO  output  1  combinational flag, high when Q == 0.

Behaviour:
- Reset:
  - R high forces Q = RESET_VAL and COUT = 0 immediately, with no clock needed.
  - Q_ = ~RESET_VAL and ZERO reflects RESET_VAL.
  - While R is high, all clock edges are ignored.
  - R deasserting mid-operation: the first active edge after deassertion performs a normal update.
- Active edge is falling if NEGEDGE = 1, else rising. Updates occur only on the active edge with R low and EN high; latency is 1 active edge.
- EN = 0: Q and COUT hold.
- MODE encoding (mode / next Q / next COUT):
  - 000 HOLD: Q, COUT unchanged (COUT holds).
  - 001 LOAD: D, 0.
  - 010 SHL: {Q[WIDTH-2:0], SIN}, Q[WIDTH-1].
  - 011 SHR: {SIN, Q[WIDTH-1:1]}, Q[0].
  - 100 ROL: {Q[WIDTH-2:0], Q[WIDTH-1]}, Q[WIDTH-1].
  - 101 ROR: {Q[0], Q[WIDTH-1:1]}, Q[0].
  - 110 INC: Q+1 modulo 2^WIDTH, 1 exactly when Q was all ones (wrap to 0).
  - 111 DEC: Q-1 modulo 2^WIDTH, 1 exactly when Q was 0 (wrap to all ones).
- Arithmetic is unsigned, WIDTH+1 bits internally; the MSB becomes COUT.
- Simultaneous events:
  - R has priority over the clock edge, EN and MODE.
  - MODE and D are sampled only at the active edge; changes between edges have no effect.
- ZERO and Q_ are derived combinationally from registered Q; no extra latency.

Decomposition:
- Shared package univ_reg_pkg holds the MODE encoding constants (HOLD, LOAD, SHL, SHR, ROL, ROR, INC, DEC) and the MODE field width (3).
- One sub-module, univ_reg_next: purely combinational. It computes next Q and next COUT from Q, COUT, D, SIN and MODE.
- The top level contains the EN gate, the edge-selected state register with asynchronous reset, and the Q_ and ZERO outputs.

Test Plan:
- WIDTH=8, RESET_VAL=8'hA5: assert R between edges → Q = A5, Q_ = 5A, COUT = 0 without any clock edge. Toggle CLK with R high and MODE=LOAD, D=00 → Q stays A5.
- NEGEDGE=1, LOAD D=3C with EN=1 → Q unchanged on the rising edge, Q = 3C after the falling edge. Repeat with EN=0, D=FF → Q stays 3C.
- Q=81:
  - SHL with SIN=0 → Q = 02, COUT = 1.
  - Then SHR with SIN=1 → Q = 81, COUT = 0.
  - Then ROR → Q = C0, COUT = 1.
- Q=FF, INC → Q = 00, COUT = 1, ZERO = 1. Then DEC → Q = FF, COUT = 1. Then DEC → Q = FE, COUT = 0.
- Q=10, INC each active edge; assert R asynchronously after 3 edges (Q = 13) → Q = RESET_VAL at once. After R falls, the next edge gives RESET_VAL + 1.
- NEGEDGE=0, WIDTH=16, RESET_VAL=0: LOAD 8000 on the rising edge, then ROL → Q = 0001, COUT = 1. No change occurs on falling edges.
